// File: rtl/cpu_pkg.sv
// Shared types and encodings for the accumulator CPU sequencer: FSM states, opcodes,
// ALU op_select codes and instruction field positions.
package cpu_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExecute,
    StWriteback,
    StHalted
  } state_t;

  localparam logic [3:0] OpNop  = 4'h0;
  localparam logic [3:0] OpLoad = 4'h1;
  localparam logic [3:0] OpAdd  = 4'h2;
  localparam logic [3:0] OpSub  = 4'h3;
  localparam logic [3:0] OpAnd  = 4'h4;
  localparam logic [3:0] OpOr   = 4'h5;
  localparam logic [3:0] OpXor  = 4'h6;
  localparam logic [3:0] OpOut  = 4'h7;
  localparam logic [3:0] OpJmp  = 4'h8;
  localparam logic [3:0] OpJz   = 4'h9;
  localparam logic [3:0] OpHalt = 4'hF;

  // ALU op_select encodings; SUB shares AluAdd with alu_sub set.
  localparam logic [2:0] AluAdd   = 3'd0;
  localparam logic [2:0] AluAnd   = 3'd1;
  localparam logic [2:0] AluOr    = 3'd2;
  localparam logic [2:0] AluXor   = 3'd3;
  localparam logic [2:0] AluPassB = 3'd4;

  localparam int unsigned InstrW   = 16;
  localparam int unsigned OpcodeHi = 15;
  localparam int unsigned OpcodeLo = 12;
  localparam int unsigned OutIdxHi = 8;
  localparam int unsigned OutIdxLo = 4;
  localparam int unsigned AddrHi   = 3;
  localparam int unsigned AddrLo   = 0;

  function automatic logic [3:0] opcode_of(input logic [InstrW-1:0] instr);
    return instr[OpcodeHi:OpcodeLo];
  endfunction

endpackage

// File: rtl/cpu_decode.sv
// Combinational opcode decoder: ALU control and instruction class flags.
module cpu_decode
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  output logic [2:0] alu_op,
  output logic       alu_sub,
  output logic       is_alu,
  output logic       is_out,
  output logic       is_jmp,
  output logic       is_jz,
  output logic       is_halt
);

  always_comb begin
    alu_op  = AluAdd;
    alu_sub = 1'b0;
    is_alu  = 1'b0;
    is_out  = 1'b0;
    is_jmp  = 1'b0;
    is_jz   = 1'b0;
    is_halt = 1'b0;
    case (opcode)
      OpLoad: begin
        alu_op = AluPassB;
        is_alu = 1'b1;
      end
      OpAdd: is_alu = 1'b1;
      OpSub: begin
        alu_sub = 1'b1;
        is_alu  = 1'b1;
      end
      OpAnd: begin
        alu_op = AluAnd;
        is_alu = 1'b1;
      end
      OpOr: begin
        alu_op = AluOr;
        is_alu = 1'b1;
      end
      OpXor: begin
        alu_op = AluXor;
        is_alu = 1'b1;
      end
      OpOut:  is_out  = 1'b1;
      OpJmp:  is_jmp  = 1'b1;
      OpJz:   is_jz   = 1'b1;
      OpHalt: is_halt = 1'b1;
      default: ;  // NOP and reserved opcodes
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer owning the PC, IR and
// retired-instruction counter, with run/step/halt control.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W  = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              step,
  input  logic [15:0]       instr_i,
  input  logic              zero_i,
  output logic [PC_W-1:0]   pc_o,
  output logic              ir_load,
  output logic              acc_load,
  output logic [2:0]        alu_op,
  output logic              alu_sub,
  output logic              out_we,
  output logic [4:0]        out_index,
  output logic              busy,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  state_t            state_q;
  logic [15:0]       ir_q;
  logic              run_q;
  logic              jz_taken_q;

  logic [3:0]        dec_opcode;
  logic [2:0]        dec_alu_op;
  logic              dec_alu_sub;
  logic              dec_is_alu;
  logic              dec_is_out;
  logic              dec_is_jmp;
  logic              dec_is_jz;
  logic              dec_is_halt;
  logic              take_branch;
  logic              unused_ir;

  // During FETCH the IR is not loaded yet, so decode the ROM word directly; this lets the
  // ALU controls be registered on entry to DECODE.
  assign dec_opcode = (state_q == StFetch) ? opcode_of(instr_i) : opcode_of(ir_q);

  cpu_decode u_decode (
    .opcode  (dec_opcode),
    .alu_op  (dec_alu_op),
    .alu_sub (dec_alu_sub),
    .is_alu  (dec_is_alu),
    .is_out  (dec_is_out),
    .is_jmp  (dec_is_jmp),
    .is_jz   (dec_is_jz),
    .is_halt (dec_is_halt)
  );

  assign take_branch = dec_is_jmp | (dec_is_jz & jz_taken_q);
  assign unused_ir   = ^ir_q[11:4];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      ir_q       <= '0;
      run_q      <= 1'b1;
      jz_taken_q <= 1'b0;
      pc_o       <= '0;
      ir_load    <= 1'b0;
      acc_load   <= 1'b0;
      alu_op     <= '0;
      alu_sub    <= 1'b0;
      out_we     <= 1'b0;
      out_index  <= '0;
      busy       <= 1'b0;
      halted     <= 1'b0;
      retired    <= '0;
    end else begin
      ir_load  <= 1'b0;
      acc_load <= 1'b0;
      out_we   <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start || step) begin
            state_q <= StFetch;
            run_q   <= start;  // start wins over step
            ir_load <= 1'b1;
            busy    <= 1'b1;
          end
        end
        StFetch: begin
          state_q   <= StDecode;
          ir_q      <= instr_i;
          alu_op    <= dec_alu_op;
          alu_sub   <= dec_alu_sub;
          out_index <= instr_i[OutIdxHi:OutIdxLo];
        end
        StDecode: state_q <= StExecute;
        StExecute: begin
          jz_taken_q <= zero_i;
          if (dec_is_halt) begin
            state_q   <= StHalted;
            halted    <= 1'b1;
            busy      <= 1'b0;
            alu_op    <= '0;
            alu_sub   <= 1'b0;
            out_index <= '0;
          end else begin
            state_q  <= StWriteback;
            acc_load <= dec_is_alu;
            out_we   <= dec_is_out;
          end
        end
        StWriteback: begin
          if (take_branch) begin
            pc_o <= PC_W'(ir_q[AddrHi:AddrLo]);
          end else begin
            pc_o <= pc_o + PC_W'(1);
          end
          if (retired != '1) begin
            retired <= retired + CNT_W'(1);
          end
          alu_op    <= '0;
          alu_sub   <= 1'b0;
          out_index <= '0;
          ir_load   <= run_q;
          busy      <= run_q;
          state_q   <= run_q ? StFetch : StIdle;
        end
        StHalted: begin
          if (start) begin
            state_q <= StFetch;
            run_q   <= 1'b1;
            pc_o    <= '0;
            halted  <= 1'b0;
            ir_load <= 1'b1;
            busy    <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer with a small ROM, data table and accumulator model.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  localparam int unsigned PcW  = 4;
  localparam int unsigned CntW = 4;  // narrow counter so saturation is reachable quickly

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic            step = 1'b0;
  logic [15:0]     instr_i;
  logic            zero_i = 1'b0;
  logic [PcW-1:0]  pc_o;
  logic            ir_load;
  logic            acc_load;
  logic [2:0]      alu_op;
  logic            alu_sub;
  logic            out_we;
  logic [4:0]      out_index;
  logic            busy;
  logic            halted;
  logic [CntW-1:0] retired;

  logic [15:0] rom [16];
  logic [7:0]  data [16];
  logic [7:0]  acc = '0;

  int n_checks = 0;
  int n_pass   = 0;

  cpu_sequencer #(.PC_W(PcW), .CNT_W(CntW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .step      (step),
    .instr_i   (instr_i),
    .zero_i    (zero_i),
    .pc_o      (pc_o),
    .ir_load   (ir_load),
    .acc_load  (acc_load),
    .alu_op    (alu_op),
    .alu_sub   (alu_sub),
    .out_we    (out_we),
    .out_index (out_index),
    .busy      (busy),
    .halted    (halted),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  assign instr_i = rom[pc_o];

  // Accumulator datapath model; B operand comes from the data table at the address field.
  always @(posedge clk) begin
    if (acc_load) begin
      logic [7:0] b;
      b = data[rom[pc_o][3:0]];
      case (alu_op)
        AluAdd:   acc <= alu_sub ? acc - b : acc + b;
        AluAnd:   acc <= acc & b;
        AluOr:    acc <= acc | b;
        AluXor:   acc <= acc ^ b;
        AluPassB: acc <= b;
        default:  acc <= 'x;
      endcase
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    start = 1'b0;
    step  = 1'b0;
    zero_i = 1'b0;
    tick(1);
    reset = 1'b0;
    acc = '0;
  endtask

  task automatic fill_rom(input logic [15:0] w);
    for (int i = 0; i < 16; i++) rom[i] = w;
  endtask

  int acc_cyc [$];
  int out_cyc;
  int out_val;
  int out_idx;

  initial begin
    for (int i = 0; i < 16; i++) data[i] = 8'(i);
    data[2] = 8'd7;
    data[3] = 8'd5;

    // Program: LOAD 2, ADD 3, OUT idx5, HALT
    fill_rom(16'h0000);
    rom[0] = 16'h1002;
    rom[1] = 16'h2003;
    rom[2] = 16'h7050;
    rom[3] = 16'hF000;
    apply_reset();
    check("reset_pc", 32'(pc_o), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_halted", 32'(halted), 0);
    check("reset_retired", 32'(retired), 0);
    check("reset_strobes", {29'd0, ir_load, acc_load, out_we}, 0);
    check("reset_alu_op", 32'(alu_op), 0);

    start = 1'b1;
    out_cyc = -1;
    out_val = -1;
    out_idx = -1;
    for (int i = 1; i <= 16; i++) begin
      tick(1);
      start = 1'b0;
      if (i == 1) check("fetch_ir_load", 32'(ir_load), 1);
      if (i == 2) check("decode_alu_op_load", 32'(alu_op), 32'(AluPassB));
      if (acc_load) acc_cyc.push_back(i);
      if (out_we) begin
        out_cyc = i;
        out_val = 32'(acc);
        out_idx = 32'(out_index);
      end
    end
    check("prog_acc_load_count", 32'(acc_cyc.size()), 2);
    if (acc_cyc.size() == 2) begin
      check("prog_acc_load_c1", 32'(acc_cyc[0]), 4);
      check("prog_acc_load_c2", 32'(acc_cyc[1]), 8);
    end
    check("prog_out_cycle", 32'(out_cyc), 12);
    check("prog_out_value", 32'(out_val), 12);
    check("prog_out_index", 32'(out_idx), 5);
    check("prog_halted", 32'(halted), 1);
    check("prog_busy", 32'(busy), 0);
    check("prog_retired", 32'(retired), 3);
    check("prog_pc", 32'(pc_o), 3);

    // step is ignored in HALTED; start restarts from PC 0
    step = 1'b1;
    tick(1);
    step = 1'b0;
    tick(2);
    check("halt_step_ignored", 32'({halted, busy}), 32'b10);
    check("halt_step_pc", 32'(pc_o), 3);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("restart_pc", 32'(pc_o), 0);
    check("restart_halted", 32'(halted), 0);
    check("restart_busy", 32'(busy), 1);

    // Single step on ADD
    fill_rom(16'h2003);
    apply_reset();
    step = 1'b1;
    tick(1);
    step = 1'b0;
    tick(3);
    check("step_wb_acc_load", 32'(acc_load), 1);
    tick(1);
    check("step_idle_busy", 32'(busy), 0);
    check("step_pc1", 32'(pc_o), 1);
    check("step_retired1", 32'(retired), 1);
    tick(6);
    check("step_no_continue", 32'(pc_o), 1);
    step = 1'b1;
    tick(1);
    step = 1'b0;
    tick(4);
    check("step_pc2", 32'(pc_o), 2);

    // JZ 9 taken: zero_i high only during EXECUTE
    fill_rom(16'h9009);
    apply_reset();
    step = 1'b1;
    tick(1);
    step = 1'b0;
    tick(2);
    zero_i = 1'b1;
    tick(1);
    zero_i = 1'b0;
    tick(1);
    check("jz_taken_pc", 32'(pc_o), 9);

    // JZ 9 not taken: zero_i low only during EXECUTE
    apply_reset();
    zero_i = 1'b1;
    step = 1'b1;
    tick(1);
    step = 1'b0;
    tick(2);
    zero_i = 1'b0;
    tick(1);
    zero_i = 1'b1;
    tick(1);
    check("jz_not_taken_pc", 32'(pc_o), 1);

    // Run through NOPs to PC 15, then JMP 0; counter saturates along the way
    fill_rom(16'h0000);
    rom[15] = 16'h8000;
    apply_reset();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(60);
    check("run_pc15", 32'(pc_o), 15);
    check("run_retired15", 32'(retired), 15);
    tick(4);
    check("jmp0_from_15", 32'(pc_o), 0);
    check("retired_saturated", 32'(retired), 15);

    // NOP at PC 15 wraps to 0
    rom[15] = 16'h0000;
    apply_reset();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(64);
    check("nop_wrap_pc", 32'(pc_o), 0);

    // start during DECODE of a stepped instruction is dropped
    fill_rom(16'h2003);
    apply_reset();
    step = 1'b1;
    tick(1);
    step = 1'b0;
    tick(1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(2);
    check("busy_start_ignored_busy", 32'(busy), 0);
    tick(5);
    check("busy_start_ignored_pc", 32'(pc_o), 1);

    // start and step together: run mode wins
    apply_reset();
    start = 1'b1;
    step  = 1'b1;
    tick(1);
    start = 1'b0;
    step  = 1'b0;
    tick(4);
    check("start_wins_busy", 32'({busy, ir_load}), 32'b11);
    tick(4);
    check("start_wins_pc", 32'(pc_o), 2);

    // Asynchronous reset mid-EXECUTE of the second instruction
    fill_rom(16'h1002);
    apply_reset();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(6);
    check("pre_reset_pc", 32'(pc_o), 1);
    check("pre_reset_alu_op", 32'(alu_op), 32'(AluPassB));
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_pc", 32'(pc_o), 0);
    check("async_reset_busy", 32'(busy), 0);
    check("async_reset_alu_op", 32'(alu_op), 0);
    check("async_reset_retired", 32'(retired), 0);
    tick(1);
    check("async_reset_no_acc_load", 32'(acc_load), 0);
    reset = 1'b0;
    tick(2);
    check("after_reset_idle", 32'({busy, pc_o}), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control FSM that sequences the accumulator CPU datapath. It replaces the free-running program counter: it owns the 4-bit PC, steps each instruction through fetch, decode, execute and writeback, and drives the ALU, accumulator and output-register control strobes. Software-visible run/step/halt control sits on top. Instantiated inside the CPU top level between the instruction ROM and the ALU/accumulator/output register.

## Interface
- PC_W, 4, program counter width (ROM depth 2^PC_W)
- CNT_W, 16, retired-instruction counter width
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  pulse: run continuously from current PC
- step  in  1  pulse: execute exactly one instruction
- instr_i  in  16  instruction word at pc_o
- zero_i  in  1  ALU ZO flag
- pc_o  out  PC_W  current program counter
- ir_load  out  1  latch instr_i into internal IR
- acc_load  out  1  accumulator write enable
- alu_op  out  3  ALU op_select
- alu_sub  out  1  ALU sub
- out_we  out  1  output-register write enable
- out_index  out  5  output-register slot
- busy  out  1  instruction in flight
- halted  out  1  HALT executed
- retired  out  CNT_W  completed-instruction count

## Operation
- Instruction format: [15:12] opcode, [8:4] out_index, [3:0] data/jump address.
- Opcodes: 0 NOP, 1 LOAD (op_select pass-B), 2 ADD, 3 SUB (alu_sub=1), 4 AND, 5 OR, 6 XOR, 7 OUT, 8 JMP, 9 JZ, F HALT; 10–E treated as NOP.
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALTED.
- IDLE: start → FETCH (mode=run); step → FETCH (mode=step); start and step together → start wins.
- FETCH: ir_load=1 → DECODE. DECODE → EXECUTE. EXECUTE: alu_op/alu_sub driven from IR; zero_i sampled into jz_taken → WRITEBACK.
- WRITEBACK: acc_load=1 for opcodes 1–6; out_we=1 for OUT. PC update: JMP → addr; JZ with jz_taken → addr; otherwise PC+1 mod 2^PC_W (15 wraps to 0). retired increments, saturating at all-ones. Next: run mode → FETCH, step mode → IDLE.
- HALT: EXECUTE → HALTED directly; PC unchanged; retired not incremented; halted=1.
- HALTED: start → PC=0, halted=0, FETCH (run); step ignored.
- start/step while busy ignored (no queuing).
- alu_op, alu_sub, out_index held valid from DECODE through WRITEBACK; 0 otherwise.

## Timing
- Reset (async, any state, mid-instruction included): state=IDLE, pc_o=0, IR=0, all strobes 0, busy=0, halted=0, retired=0, mode=run.
- 4 cycles per instruction; run mode throughput one instruction per 4 clk.
- start sampled at edge t → FETCH at t+1; first acc_load at t+4.
- busy=1 in FETCH/DECODE/EXECUTE/WRITEBACK.
- ir_load, acc_load, out_we each exactly one cycle per instruction, registered outputs (Moore).
- acc_load/out_we edge and PC update occur on the same clock edge; OUT writes pre-update accumulator value.
- zero_i sampled only in EXECUTE; changes elsewhere ignored.

## Structure
- Package cpu_pkg: state enum, opcode localparams, op_select encodings, instruction field positions.
- One combinational sub-module cpu_decode: opcode → alu_op, alu_sub, is_alu, is_out, is_jmp, is_jz, is_halt.
- Sequencer FSM, PC, IR, mode, jz_taken, counter in cpu_sequencer.

## Test plan
- Reset then start; ROM {LOAD 2, ADD 3, OUT idx5, HALT}, data[2]=7, data[3]=5 → acc_load at cycles 4 and 8, out_we with out_index=5 at cycle 12 writing 12, halted=1, retired=3, pc_o=3.
- step pulse on ROM of ADD → exactly one instruction, state IDLE after 4 cycles, pc_o=1, retired=1; second step → pc_o=2.
- JZ 9 with zero_i=1 in EXECUTE → pc_o=9; same with zero_i=0 → pc_o=PC+1; JMP 0 from PC 15 and NOP at PC 15 → both reach 0.
- start asserted during DECODE → ignored; start+step same cycle from IDLE → run mode continues past first instruction.
- reset asserted mid-EXECUTE → outputs cleared immediately without clock edge; no acc_load; PC=0.
- Force retired to all-ones, retire NOP → stays all-ones; start from HALTED → pc_o=0, halted=0.
